snake_core: RTL and testbench
=============================

# snake_core

Parametrised snake-body engine for the VGA snake game: it holds up to MAX_LEN segments, advances the snake one grid cell per movement tick, and buffers player direction requests in a 2-entry queue. It detects wall and self collisions against the next head position, tracks pending growth, and answers the pixel scanner with a registered cell class. It sits between the key debouncers/apple logic and the VGA colour mux.

## Interface
- GRID_W, 40: playfield width in cells, including the border wall columns
- GRID_H, 30: playfield height in cells, including the border wall rows
- CELL_BITS, 6: width of the cell coordinates
- MAX_LEN, 16: maximum snake length, 4..64
- INIT_LEN, 3: length after reset or restart
- INIT_X, 10 / INIT_Y, 5: head cell after reset
- TICK_DIV, 12_500_000: clk cycles per step (0.25 s at 50 MHz)
- TILE_SHIFT, 4: log2 of the cell size in pixels
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- restart  in  1  return to the initial snake (same effect as rst)
- start  in  1  pulse: IDLE->RUN
- dir_valid  in  1  direction request strobe
- dir_code  in  2  00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
- grow  in  1  apple eaten; level, counted on its rising edge
- x_pos, y_pos  in  10 each  scan pixel coordinate
- blink_on  in  1  0 blanks head/body in pix_class
- pix_class  out  2  00 NONE, 01 HEAD, 10 BODY, 11 WALL
- head_x, head_y  out  CELL_BITS each  current head cell
- length  out  clog2(MAX_LEN+1)  current segment count
- state  out  2  00 IDLE, 01 RUN, 10 DEAD
- hit_wall, hit_body  out  1 each  sticky collision flags
- step  out  1  one-cycle pulse on every move

## Operation
- Reset values (rst low or restart high): state IDLE; segment i at (INIT_X-i, INIT_Y) for i<INIT_LEN; segments beyond INIT_LEN at (0,0) and invalid; direction RIGHT; length=INIT_LEN; queue empty; pending grow 0; tick counter 0; hit flags 0; step 0; pix_class 00. rst has priority over restart; both take priority over all other inputs.
- IDLE: start -> RUN with the tick counter at 0. In RUN, start is ignored.
- RUN: the tick counter counts 0..TICK_DIV-1. At the terminal count a step is taken and the counter wraps to 0.
- Direction queue, 2 deep. A request is pushed only if it is neither equal nor opposite to the last queued direction, or to the current direction when the queue is empty. Requests are dropped when the queue is full. Requests are accepted in every state and cleared by reset.
- Step:
  - Pop one queue entry if present; it becomes the direction for this step.
  - Compute the next head.
  - Next head on a border cell (x=0, x=GRID_W-1, y=0, y=GRID_H-1): set hit_wall, go to DEAD, no movement.
  - Else, next head equals any valid segment 1..length-1: set hit_body, go to DEAD. The tail segment is excluded when no growth is pending.
  - Else: shift all segments one place and load the new head. If pending>0 and length<MAX_LEN: length+1 (the old tail is retained) and pending-1. Pulse step.
- Growth: each grow rising edge increments pending, saturating at MAX_LEN-length. A grow edge in the same cycle as a step takes effect on the following step.
- DEAD: everything is frozen until rst or restart.
- pix_class: registered, 1-cycle latency from x_pos/y_pos.
  - Cell = pos>>TILE_SHIFT.
  - Output 00 for pixels outside 640x480.
  - Priority order: WALL, then HEAD, then BODY.
  - HEAD/BODY become NONE when blink_on=0.

## Timing
- Step to outputs: head_x/head_y/length/state/hit flags are updated on the clock edge that closes the terminal count. step is high during the following cycle.
- Reverse-request rejection is decided at push time against queue contents; two valid turns within one tick both execute on successive steps.
- dir_valid in the step cycle is pushed after the pop. It is evaluated against the post-pop direction.

## Configuration
- SNAKE_WRAP_EN defined: crossing a border wraps the head to the opposite interior cell (x=1 <-> GRID_W-2, y=1 <-> GRID_H-2). hit_wall is never set, and borders are still rendered as WALL.
- Undefined: borders are lethal as described above.

## Test plan
- Reset, start, TICK_DIV=4, no input -> head_x 10,11,12… once every 4 cycles; length stays 3; step pulses once per move.
- In RUN heading RIGHT, dir_valid LEFT -> dropped; UP then LEFT within one tick -> next two steps move up, then left.
- grow pulse with MAX_LEN=4 from length 3, then three more grow edges -> length 4 after the next step, then saturates at 4.
- Head at x=38 heading RIGHT, GRID_W=40 -> hit_wall=1, state=10, head_x stays 38; with SNAKE_WRAP_EN -> head_x=1, no hit.
- Length-5 snake turns U,L,D on consecutive steps -> hit_body=1 and DEAD. Same with length 4 chasing its tail -> no hit.
- restart asserted mid-RUN with 2 queued requests -> next cycle state IDLE, head (10,5), length 3, queue empty; pix_class at pixel (160,80) = HEAD one cycle later.

Source files
------------

// File: rtl/snake_core.sv
// snake_core: snake body, 2-deep turn queue, collision detect and cell classifier.
// Optional SNAKE_WRAP_EN: borders wrap to the opposite interior cell instead of killing.
module snake_core #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int CELL_BITS  = 6,
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int INIT_X     = 10,
  parameter int INIT_Y     = 5,
  parameter int TICK_DIV   = 12_500_000,
  parameter int TILE_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         start,
  input  logic                         dir_valid,
  input  logic [1:0]                   dir_code,
  input  logic                         grow,
  input  logic [9:0]                   x_pos,
  input  logic [9:0]                   y_pos,
  input  logic                         blink_on,
  output logic [1:0]                   pix_class,
  output logic [CELL_BITS-1:0]         head_x,
  output logic [CELL_BITS-1:0]         head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic [1:0]                   state,
  output logic                         hit_wall,
  output logic                         hit_body,
  output logic                         step
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TICK_DIV + 1);

  typedef logic [CELL_BITS-1:0] cell_t;
  typedef logic [LW-1:0] len_t;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam logic [1:0] D_UP = 2'b00;
  localparam logic [1:0] D_DN = 2'b01;
  localparam logic [1:0] D_LT = 2'b10;
  localparam logic [1:0] D_RT = 2'b11;

  localparam cell_t X_MAX = cell_t'(GRID_W - 1);
  localparam cell_t Y_MAX = cell_t'(GRID_H - 1);
  localparam len_t  L_MAX = len_t'(MAX_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  state_t st, st_n;

  cell_t seg_x [MAX_LEN];
  cell_t seg_y [MAX_LEN];

  logic [1:0] dir, dir_n;
  logic [1:0] q0, q0_n;
  logic [1:0] q1, q1_n;
  logic [1:0] qn, qn_n;
  logic [1:0] pop_dir, ref_dir;

  len_t len, len_n;
  len_t pend, pend_n;

  logic [TW-1:0] tick;
  logic grow_d;
  logic hw, hb;
  logic step_r;
  logic [1:0] pix, pix_n;

  cell_t nx, ny;
  logic tick_end;
  logic wall, body;
  logic move, die;
  logic grow_rise, grow_inc;

  logic [9:0] cx, cy;
  logic in_view, is_wall, is_head, is_body;

  // Next head and collision check for the step being taken
  always_comb begin
    tick_end = (st == RUN) && (tick == T_LAST);
    pop_dir  = (qn != 2'd0) ? q0 : dir;
    nx = seg_x[0];
    ny = seg_y[0];
    unique case (pop_dir)
      D_UP: ny = seg_y[0] - 1'b1;
      D_DN: ny = seg_y[0] + 1'b1;
      D_LT: nx = seg_x[0] - 1'b1;
      D_RT: nx = seg_x[0] + 1'b1;
      default: nx = seg_x[0];
    endcase
    wall = 1'b0;
`ifdef SNAKE_WRAP_EN
    if (nx == '0)
      nx = X_MAX - 1'b1;
    else if (nx == X_MAX)
      nx = cell_t'(1);
    if (ny == '0)
      ny = Y_MAX - 1'b1;
    else if (ny == Y_MAX)
      ny = cell_t'(1);
`else
    wall = (nx == '0) || (nx == X_MAX) ||
           (ny == '0) || (ny == Y_MAX);
`endif
    body = 1'b0;
    // The tail vacates its cell unless growth keeps it
    for (int i = 1; i < MAX_LEN; i++) begin
      if (len_t'(i) < len &&
          (len_t'(i) != len - 1'b1 || pend != '0) &&
          seg_x[i] == nx && seg_y[i] == ny)
        body = 1'b1;
    end
    die  = tick_end && (wall || body);
    move = tick_end && !wall && !body;
  end

  always_comb begin
    q0_n  = q0;
    q1_n  = q1;
    qn_n  = qn;
    dir_n = dir;
    if (tick_end) begin
      dir_n = pop_dir;
      if (qn != 2'd0) begin
        q0_n = q1;
        qn_n = qn - 1'b1;
      end
    end
    ref_dir = dir_n;
    if (qn_n == 2'd1)
      ref_dir = q0_n;
    else if (qn_n == 2'd2)
      ref_dir = q1_n;
    // Same axis means equal or opposite
    if (dir_valid && qn_n != 2'd2 &&
        dir_code[1] != ref_dir[1]) begin
      if (qn_n == 2'd0)
        q0_n = dir_code;
      else
        q1_n = dir_code;
      qn_n = qn_n + 1'b1;
    end
  end

  always_comb begin
    grow_rise = grow && !grow_d;
    grow_inc  = move && (pend != '0) && (len < L_MAX);
    len_n  = len + len_t'(grow_inc);
    pend_n = pend - len_t'(grow_inc);
    if (grow_rise && st != DEAD && pend_n < L_MAX - len_n)
      pend_n = pend_n + 1'b1;
  end

  always_comb begin
    cx = x_pos >> TILE_SHIFT;
    cy = y_pos >> TILE_SHIFT;
    in_view = (x_pos < 10'd640) && (y_pos < 10'd480);
    is_wall = (cx == '0) || (cx == 10'(X_MAX)) ||
              (cy == '0) || (cy == 10'(Y_MAX));
    is_head = (cx == 10'(seg_x[0])) && (cy == 10'(seg_y[0]));
    is_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (len_t'(i) < len &&
          cx == 10'(seg_x[i]) && cy == 10'(seg_y[i]))
        is_body = 1'b1;
    end
    pix_n = 2'b00;
    if (in_view) begin
      if (is_wall)
        pix_n = 2'b11;
      else if (blink_on && is_head)
        pix_n = 2'b01;
      else if (blink_on && is_body)
        pix_n = 2'b10;
    end
  end

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:    if (start) st_n = RUN;
      RUN:     if (die) st_n = DEAD;
      DEAD:    st_n = DEAD;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || restart)
      st <= IDLE;
    else
      st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? cell_t'(INIT_X - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? cell_t'(INIT_Y) : '0;
      end
      dir    <= D_RT;
      q0     <= 2'b00;
      q1     <= 2'b00;
      qn     <= 2'd0;
      len    <= len_t'(INIT_LEN);
      pend   <= '0;
      tick   <= '0;
      grow_d <= grow;
      hw     <= 1'b0;
      hb     <= 1'b0;
      step_r <= 1'b0;
      pix    <= 2'b00;
    end else begin
      dir    <= dir_n;
      q0     <= q0_n;
      q1     <= q1_n;
      qn     <= qn_n;
      len    <= len_n;
      pend   <= pend_n;
      grow_d <= grow;
      step_r <= move;
      pix    <= pix_n;
      if (st == RUN)
        tick <= tick_end ? '0 : tick + 1'b1;
      if (move) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nx;
        seg_y[0] <= ny;
      end
      if (die) begin
        if (wall)
          hw <= 1'b1;
        else
          hb <= 1'b1;
      end
    end
  end

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign length    = len;
  assign state     = st;
  assign hit_wall  = hw;
  assign hit_body  = hb;
  assign step      = step_r;
  assign pix_class = pix;

endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: directed moves scored against a queue of expected head/length/state records.
// Small geometry: MAX_LEN=5, TICK_DIV=4, 40x30 grid, head starts at (10,5).
module tb_snake_core;

  localparam int LW = $clog2(5 + 1);

  logic          clk;
  logic          rst;
  logic          restart;
  logic          start;
  logic          dir_valid;
  logic [1:0]    dir_code;
  logic          grow;
  logic [9:0]    x_pos;
  logic [9:0]    y_pos;
  logic          blink_on;
  logic [1:0]    pix_class;
  logic [5:0]    head_x;
  logic [5:0]    head_y;
  logic [LW-1:0] length;
  logic [1:0]    state;
  logic          hit_wall;
  logic          hit_body;
  logic          step;

  snake_core #(
    .MAX_LEN (5),
    .TICK_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .start    (start),
    .dir_valid(dir_valid),
    .dir_code (dir_code),
    .grow     (grow),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .blink_on (blink_on),
    .pix_class(pix_class),
    .head_x   (head_x),
    .head_y   (head_y),
    .length   (length),
    .state    (state),
    .hit_wall (hit_wall),
    .hit_body (hit_body),
    .step     (step)
  );

  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] LT = 2'b10;
  localparam logic [1:0] RT = 2'b11;

  typedef struct {
    int id;
    int hx;
    int hy;
    int ln;
    int st;
    int hw;
    int hb;
    int cy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int s;
  logic [1:0] prev_st = 2'b00;
  logic ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: every move pulse or entry into DEAD consumes one expected record
  always @(negedge clk) begin
    if (step || (state == 2'b10 && prev_st != 2'b10)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event head=(%0d,%0d) len=%0d st=%0d required no event",
                 head_x, head_y, length, state);
      end else begin
        mon_e = sb.pop_front();
        ok = (head_x == mon_e.hx) && (head_y == mon_e.hy) &&
             (length == mon_e.ln) && (state == mon_e.st) &&
             (hit_wall == mon_e.hw) && (hit_body == mon_e.hb);
        if (mon_e.cy >= 0 && cyc != mon_e.cy)
          ok = 1'b0;
        if (!ok) begin
          fails++;
          $display("FAIL move_%0d got head=(%0d,%0d) len=%0d st=%0d hw=%0d hb=%0d cyc=%0d required head=(%0d,%0d) len=%0d st=%0d hw=%0d hb=%0d cyc=%0d",
                   mon_e.id, head_x, head_y, length, state, hit_wall, hit_body, cyc,
                   mon_e.hx, mon_e.hy, mon_e.ln, mon_e.st, mon_e.hw, mon_e.hb, mon_e.cy);
        end
      end
    end
    prev_st <= state;
  end

  function automatic void push(input int id, input int hx, input int hy,
                               input int ln, input int st, input int hw,
                               input int hb, input int cy);
    exp_t e;
    e.id = id; e.hx = hx; e.hy = hy; e.ln = ln;
    e.st = st; e.hw = hw; e.hb = hb; e.cy = cy;
    sb.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic wait_sb(input int target, input int bound);
    int n = 0;
    while (sb.size() > target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > target) begin
      tests++;
      fails++;
      $display("FAIL timeout_wait got %0d pending required %0d", sb.size(), target);
      while (sb.size() > target) void'(sb.pop_front());
    end
  endtask

  task automatic send_dir(input logic [1:0] d);
    dir_valid = 1'b1;
    dir_code  = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic pix_chk(input string nm, input int x, input int y,
                         input logic b, input int req);
    x_pos    = 10'(x);
    y_pos    = 10'(y);
    blink_on = b;
    @(negedge clk);
    chk(nm, pix_class, req);
  endtask

  initial begin
    rst = 1'b0; restart = 1'b0; start = 1'b0;
    dir_valid = 1'b0; dir_code = 2'b00; grow = 1'b0;
    x_pos = 10'd0; y_pos = 10'd0; blink_on = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_state", state, 0);
    chk("rst_head_x", head_x, 10);
    chk("rst_head_y", head_y, 5);
    chk("rst_length", length, 3);
    chk("rst_hit_wall", hit_wall, 0);
    chk("rst_hit_body", hit_body, 0);
    chk("rst_step", step, 0);
    chk("rst_pix", pix_class, 0);
    rst = 1'b1;
    @(negedge clk);

    // Straight run: one move every 4 cycles after start
    s = cyc;
    push(1, 11, 5, 3, 1, 0, 0, s + 5);
    push(2, 12, 5, 3, 1, 0, 0, s + 9);
    push(3, 13, 5, 3, 1, 0, 0, s + 13);
    pulse_start();
    wait_sb(0, 40);

    // Reverse dropped; UP then LEFT both queued
    push(4, 13, 4, 3, 1, 0, 0, -1);
    push(5, 12, 4, 3, 1, 0, 0, -1);
    send_dir(LT);
    send_dir(UP);
    send_dir(LT);
    wait_sb(0, 40);

    // Restart with a full queue
    send_dir(UP);
    send_dir(RT);
    x_pos = 10'd160;
    y_pos = 10'd80;
    blink_on = 1'b1;
    do_restart();
    chk("restart_state", state, 0);
    chk("restart_head_x", head_x, 10);
    chk("restart_head_y", head_y, 5);
    chk("restart_length", length, 3);
    chk("restart_pix", pix_class, 0);
    @(negedge clk);
    chk("restart_pix_head", pix_class, 1);

    pix_chk("pix_body1", 150, 85, 1'b1, 2);
    pix_chk("pix_tail", 128, 95, 1'b1, 2);
    pix_chk("pix_empty", 112, 80, 1'b1, 0);
    pix_chk("pix_wall_tl", 0, 0, 1'b1, 3);
    pix_chk("pix_wall_br", 639, 479, 1'b1, 3);
    pix_chk("pix_offscreen", 700, 80, 1'b1, 0);
    pix_chk("pix_blink_head", 160, 80, 1'b0, 0);
    pix_chk("pix_blink_wall", 5, 200, 1'b0, 3);
    blink_on = 1'b1;

    // Four grow edges in IDLE saturate pending at MAX_LEN-length=2
    repeat (4) pulse_grow();
    push(6, 11, 5, 4, 1, 0, 0, -1);
    push(7, 12, 5, 5, 1, 0, 0, -1);
    push(8, 13, 5, 5, 1, 0, 0, -1);
    pulse_start();
    wait_sb(0, 40);

    // Length 5: U, L, D runs into segment 3
    push(9, 13, 4, 5, 1, 0, 0, -1);
    push(10, 12, 4, 5, 1, 0, 0, -1);
    push(11, 12, 4, 5, 2, 0, 1, -1);
    send_dir(UP);
    send_dir(LT);
    wait_sb(2, 20);
    send_dir(DN);
    wait_sb(0, 30);

    // Length 4 chases its own tail without a hit
    do_restart();
    pulse_grow();
    push(12, 11, 5, 4, 1, 0, 0, -1);
    pulse_start();
    wait_sb(0, 20);
    push(13, 11, 4, 4, 1, 0, 0, -1);
    push(14, 10, 4, 4, 1, 0, 0, -1);
    push(15, 10, 5, 4, 1, 0, 0, -1);
    push(16, 11, 5, 4, 1, 0, 0, -1);
    send_dir(UP);
    send_dir(LT);
    wait_sb(3, 20);
    send_dir(DN);
    wait_sb(2, 20);
    send_dir(RT);
    wait_sb(0, 30);

    // Right wall: last legal cell is x=38
    for (int x = 12; x <= 38; x++)
      push(100 + x, x, 5, 4, 1, 0, 0, -1);
    push(200, 38, 5, 4, 2, 1, 0, -1);
    wait_sb(0, 200);

    send_dir(UP);
    repeat (12) @(negedge clk);
    chk("dead_head_x", head_x, 38);
    chk("dead_state", state, 2);
    chk("dead_hit_wall", hit_wall, 1);
    chk("dead_length", length, 4);

    do_restart();
    chk("final_state", state, 0);
    chk("final_hit_wall", hit_wall, 0);
    chk("final_head_x", head_x, 10);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
